// File: rtl/spi_peripheral_regfile.sv
// spi_peripheral_regfile
//
// SPI mode-0 peripheral in front of a bank of REG_N registers of REG_WIDTH
// bits each. Every frame starts with an 11-bit header (bit10 = WnR, bits9:0
// = start address), followed by any number of REG_WIDTH-bit data words. The
// address advances by one after every completed word. All logic runs on
// axi_clk; the SPI pins are oversampled through 2-flop synchronizers, so
// axi_clk must be at least 4x spi_clk.
//
// Ports:
//   axi_clk    system clock, everything on its rising edge
//   reset_b    asynchronous active-low reset
//   spi_clk    SPI clock from the controller (mode 0, asynchronous)
//   cs_b       active-low chip select
//   pico       serial data from the controller, MSB first
//   poci       serial data to the controller, MSB first
//   reg_out    flat register contents, register k at [k*REG_WIDTH +: REG_WIDTH]
//   wr_strobe  one-cycle pulse when a register is written
//   wr_addr    address of the last written register
//   busy       high whenever the FSM is not IDLE
//   frame_err  one-cycle pulse when a frame ends partway through a word

`timescale 1ns/1ps

module spi_peripheral_regfile #(
  parameter int REG_WIDTH = 16,
  parameter int REG_N     = 16
) (
  input  logic                         axi_clk,
  input  logic                         reset_b,
  input  logic                         spi_clk,
  input  logic                         cs_b,
  input  logic                         pico,
  output logic                         poci,
  output logic [REG_N*REG_WIDTH-1:0]   reg_out,
  output logic                         wr_strobe,
  output logic [9:0]                   wr_addr,
  output logic                         busy,
  output logic                         frame_err
);

  // The counter must reach 10 for the header as well as REG_WIDTH-1 for data.
  localparam int CNT_W = ($clog2(REG_WIDTH + 1) > 4) ? $clog2(REG_WIDTH + 1) : 4;
  localparam int IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam logic [10:0] REG_N_L = 11'(REG_N);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t state, state_next;

  logic [2:0]           sclk_sync;
  logic [2:0]           cs_sync;
  logic [1:0]           pico_sync;
  logic [CNT_W-1:0]     bit_cnt;
  logic [9:0]           hdr_shift;
  logic [REG_WIDTH-2:0] shift_in;
  logic [REG_WIDTH-1:0] shift_out;
  logic [9:0]           addr;
  logic                 wnr;
  logic                 poci_r;
  logic [REG_WIDTH-1:0] regs [REG_N];

  logic                 spi_rise, spi_fall, cs_rise, cs_fall, cs_active, pico_s;
  logic                 hdr_done, word_done;
  logic [10:0]          hdr_word;
  logic [9:0]           addr_inc;
  logic [REG_WIDTH-1:0] rd_hdr, rd_next;

  function automatic logic in_range(input logic [9:0] a);
    return {1'b0, a} < REG_N_L;
  endfunction

  // Bits [1] of each chain are the synchronized copies; sclk_sync[2] and
  // cs_sync[2] hold the previous synchronized value so edges can be seen.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      pico_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], cs_b};
      pico_sync <= {pico_sync[0], pico};
    end
  end

  assign spi_rise  =  sclk_sync[1] & ~sclk_sync[2];
  assign spi_fall  = ~sclk_sync[1] &  sclk_sync[2];
  assign cs_rise   =  cs_sync[1]   & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1]   &  cs_sync[2];
  assign cs_active = ~cs_sync[1];
  assign pico_s    =  pico_sync[1];

  assign hdr_word  = {hdr_shift, pico_s};
  assign addr_inc  = addr + 10'd1;
  assign hdr_done  = (state == HDR)  && spi_rise && cs_active && (bit_cnt == CNT_W'(10));
  assign word_done = (state == DATA) && spi_rise && cs_active && (bit_cnt == CNT_W'(REG_WIDTH - 1));

  // Read data for the two moments the output shifter is loaded: the start
  // address straight out of the header, and the next address after a word.
  // Out-of-range addresses read as zero.
  always_comb begin
    rd_hdr  = '0;
    rd_next = '0;
    if (in_range(hdr_word[9:0])) rd_hdr  = regs[hdr_word[IDX_W-1:0]];
    if (in_range(addr_inc))      rd_next = regs[addr_inc[IDX_W-1:0]];
  end

  // FSM state register.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: chip select starts and ends frames, the 11th header
  // bit moves the FSM into the data phase.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = HDR;
      HDR:     if (cs_rise) state_next = IDLE;
               else if (hdr_done) state_next = DATA;
      DATA:    if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: header capture, word assembly, register writes and the read
  // shifter. A chip-select rise mid-word discards the word and flags an
  // error; a rise on a word boundary ends the frame quietly.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      bit_cnt   <= '0;
      hdr_shift <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      wnr       <= 1'b0;
      poci_r    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < REG_N; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && cs_rise) begin
        if (bit_cnt != '0) frame_err <= 1'b1;
        bit_cnt <= '0;
        poci_r  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            poci_r  <= 1'b0;
          end
          HDR: begin
            poci_r <= 1'b0;
            if (hdr_done) begin
              wnr       <= hdr_word[10];
              addr      <= hdr_word[9:0];
              bit_cnt   <= '0;
              shift_out <= hdr_word[10] ? '0 : rd_hdr;
            end else if (spi_rise && cs_active) begin
              hdr_shift <= hdr_word[9:0];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
          DATA: begin
            if (spi_fall && cs_active && !wnr) begin
              poci_r    <= shift_out[REG_WIDTH-1];
              shift_out <= {shift_out[REG_WIDTH-2:0], 1'b0};
            end
            if (word_done) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              if (wnr) begin
                if (in_range(addr)) begin
                  regs[addr[IDX_W-1:0]] <= {shift_in, pico_s};
                  wr_strobe             <= 1'b1;
                  wr_addr               <= addr;
                end
              end else begin
                shift_out <= rd_next;
              end
            end else if (spi_rise && cs_active) begin
              shift_in <= (REG_WIDTH-1)'({shift_in, pico_s});
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: begin
            bit_cnt <= '0;
            poci_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The raw chip select also gates poci so the line is quiet the moment the
  // controller deselects, without waiting for the synchronizer.
  assign poci = poci_r & ~cs_b;

  for (genvar k = 0; k < REG_N; k++) begin : g_out
    assign reg_out[k*REG_WIDTH +: REG_WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_spi_peripheral_regfile.sv
// tb_spi_peripheral_regfile
//
// Drives SPI frames from a vector table into spi_peripheral_regfile and
// checks register writes, read-back data, frame errors and reset behaviour
// against a small register model kept in the bench.

`timescale 1ns/1ps

module tb_spi_peripheral_regfile;

  localparam int W = 16;
  localparam int N = 16;

  logic           axi_clk = 1'b0;
  logic           reset_b = 1'b0;
  logic           spi_clk = 1'b0;
  logic           cs_b    = 1'b1;
  logic           pico    = 1'b0;
  logic           poci;
  logic [N*W-1:0] reg_out;
  logic           wr_strobe;
  logic [9:0]     wr_addr;
  logic           busy;
  logic           frame_err;

  int total   = 0;
  int bad     = 0;
  int err_cnt = 0;

  typedef struct {
    logic        wnr;
    logic [9:0]  addr;
    int          hdr_bits;
    int          nwords;
    logic [15:0] w0, w1, w2;
    int          extra;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  vec_t        vecs [14];
  logic [15:0] model [N];
  wr_t         wr_q [$];
  logic [15:0] rd_q [$];

  spi_peripheral_regfile #(.REG_WIDTH(W), .REG_N(N)) dut (
    .axi_clk   (axi_clk),
    .reset_b   (reset_b),
    .spi_clk   (spi_clk),
    .cs_b      (cs_b),
    .pico      (pico),
    .poci      (poci),
    .reg_out   (reg_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = model[k];
    return f;
  endfunction

  function automatic vec_t mkvec(input logic wnr, input logic [9:0] addr, input int hb, input int nw,
                                 input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                 input int extra);
    vec_t v;
    v.wnr = wnr; v.addr = addr; v.hdr_bits = hb; v.nwords = nw;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.extra = extra;
    return v;
  endfunction

  // Write-strobe scoreboard and frame-error counter, sampled mid-cycle.
  always @(negedge axi_clk) begin
    wr_t e;
    if (frame_err) err_cnt++;
    if (wr_strobe) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe: wr_addr=%0d with no write expected", wr_addr);
      end else begin
        e = wr_q.pop_front();
        checkOutput("wr_addr", N*W'(wr_addr), N*W'(e.addr));
        checkOutput("wr_data", N*W'(reg_out[e.addr*W +: W]), N*W'(e.data));
      end
    end
  end

  // Clock out n bits MSB first, capturing poci just before each rising edge.
  task automatic spi_bits(input logic [63:0] bits, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      pico = bits[i];
      #50;
      rx = {rx[62:0], poci};
      spi_clk = 1'b1;
      #50;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [63:0] bits, input int n, output logic [63:0] rx);
    @(negedge axi_clk);
    cs_b = 1'b0;
    #100;
    spi_bits(bits, n, rx);
    #50;
    pico = 1'b0;
    cs_b = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    checkOutput("busy_after_cs", N*W'(busy), '0);
    checkOutput("poci_idle", N*W'(poci), '0);
    #300;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [63:0] bits, rx;
    logic [10:0] hdr;
    logic [9:0]  a;
    logic [15:0] ws [3];
    logic [15:0] exp;
    int          n, err0, exp_err;
    bits = '0; n = 0; hdr = {v.wnr, v.addr}; a = v.addr; err0 = err_cnt;
    ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
    for (int i = 0; i < v.hdr_bits; i++) begin
      bits = {bits[62:0], hdr[10-i]};
      n++;
    end
    for (int j = 0; j < v.nwords; j++) begin
      if (v.wnr) begin
        for (int b = 15; b >= 0; b--) bits = {bits[62:0], ws[j][b]};
        if (int'(a) < N) begin
          model[a[3:0]] = ws[j];
          wr_q.push_back('{a, ws[j]});
        end
      end else begin
        bits = {bits[47:0], 16'h0000};
        rd_q.push_back((int'(a) < N) ? model[a[3:0]] : 16'h0000);
      end
      n += 16;
      a = a + 10'd1;
    end
    for (int i = 0; i < v.extra; i++) begin
      bits = {bits[62:0], ((i % 2) == 0)};
      n++;
    end
    exp_err = ((v.hdr_bits > 0 && v.hdr_bits < 11) || v.extra > 0) ? 1 : 0;
    spi_frame(bits, n, rx);
    if (!v.wnr && v.hdr_bits == 11) begin
      for (int j = 0; j < v.nwords; j++) begin
        exp = rd_q.pop_front();
        checkOutput("read_word", N*W'(rx[16*(v.nwords-1-j) +: 16]), N*W'(exp));
      end
    end
    checkOutput("frame_err_count", N*W'(err_cnt - err0), N*W'(exp_err));
    checkOutput("pending_writes", N*W'(wr_q.size()), '0);
    checkOutput("reg_out", reg_out, model_flat());
  endtask

  initial begin
    logic [63:0] rx;
    vecs[0]  = mkvec(1'b1, 10'd3,    11, 1, 16'hBEEF, 16'h0000, 16'h0000, 0);
    vecs[1]  = mkvec(1'b1, 10'd14,   11, 3, 16'h1111, 16'h2222, 16'h3333, 0);
    vecs[2]  = mkvec(1'b0, 10'd3,    11, 2, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[3]  = mkvec(1'b1, 10'd2,    11, 1, 16'h7777, 16'h0000, 16'h0000, 0);
    vecs[4]  = mkvec(1'b1, 10'd2,    11, 0, 16'h0000, 16'h0000, 16'h0000, 7);
    vecs[5]  = mkvec(1'b0, 10'd2,    11, 1, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[6]  = mkvec(1'b1, 10'd1023, 11, 2, 16'hAAAA, 16'h5555, 16'h0000, 0);
    vecs[7]  = mkvec(1'b0, 10'd14,   11, 2, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[8]  = mkvec(1'b0, 10'd15,   11, 2, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[9]  = mkvec(1'b0, 10'd1023, 11, 2, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[10] = mkvec(1'b1, 10'd20,   11, 1, 16'hDEAD, 16'h0000, 16'h0000, 0);
    vecs[11] = mkvec(1'b1, 10'd4,     6, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[12] = mkvec(1'b1, 10'd0,     0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[13] = mkvec(1'b1, 10'd9,    11, 2, 16'h0F0F, 16'hF0F0, 16'h0000, 0);
    for (int k = 0; k < N; k++) model[k] = 16'h0000;

    // Reset state.
    repeat (3) @(posedge axi_clk);
    #1;
    checkOutput("rst_reg_out",   reg_out,             '0);
    checkOutput("rst_poci",      N*W'(poci),      '0);
    checkOutput("rst_wr_strobe", N*W'(wr_strobe), '0);
    checkOutput("rst_wr_addr",   N*W'(wr_addr),   '0);
    checkOutput("rst_busy",      N*W'(busy),      '0);
    checkOutput("rst_frame_err", N*W'(frame_err), '0);
    @(negedge axi_clk);
    reset_b = 1'b1;
    #200;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a data word: outputs clear at once and no
    // error or write comes out of the aborted frame.
    @(negedge axi_clk);
    cs_b = 1'b0;
    #100;
    spi_bits(64'({1'b1, 10'd5, 5'b10110}), 16, rx);
    #20;
    begin
      int err0;
      err0 = err_cnt;
      reset_b = 1'b0;
      #1;
      checkOutput("midrst_reg_out",   reg_out,         '0);
      checkOutput("midrst_busy",      N*W'(busy),      '0);
      checkOutput("midrst_poci",      N*W'(poci),      '0);
      checkOutput("midrst_wr_strobe", N*W'(wr_strobe), '0);
      checkOutput("midrst_wr_addr",   N*W'(wr_addr),   '0);
      checkOutput("midrst_frame_err", N*W'(frame_err), '0);
      for (int k = 0; k < N; k++) model[k] = 16'h0000;
      #100;
      cs_b = 1'b1;
      #100;
      @(negedge axi_clk);
      reset_b = 1'b1;
      #300;
      checkOutput("midrst_no_err", N*W'(err_cnt - err0), '0);
    end
    applyStimulus(mkvec(1'b1, 10'd5, 11, 1, 16'hC0DE, 16'h0000, 16'h0000, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
